multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RISC-V core. It sits directly downstream of the instruction type decoder and consumes its one-hot class flags (r_type, i_type, load, store, branch, jal, jalr). It sequences each instruction through fetch, decode, execute, memory and writeback. It drives register, memory and PC enables, operand/writeback selects, and the instruction/data memory request handshake.

---
 rtl/multicycle_ctrl_pkg.sv | 43 ++++
 rtl/ctrl_class_enc.sv | 35 +++
 rtl/multicycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared encodings for the multi-cycle control FSM: state
//               codes, instruction class codes, PC and writeback selects.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

  // Controller states; values are visible on state_o
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // Instruction class held in the class register after DECODE
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_R      = 3'd1,
    CLS_I      = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JAL    = 3'd6,
    CLS_JALR   = 3'd7
  } class_t;

  // PC source selects
  localparam logic [1:0] c_PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] c_PC_SEL_TARGET = 2'd1;
  localparam logic [1:0] c_PC_SEL_JALR   = 2'd2;

  // Register writeback selects
  localparam logic [1:0] c_WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] c_WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] c_WB_SEL_PC4  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ctrl_class_enc.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_class_enc
// Description : Priority encoder from the type decoder's class flags to a
//               3-bit class code. Priority: jalr > jal > branch > store >
//               load > i_type > r_type; no flag yields CLS_NONE.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_class_enc
  import multicycle_ctrl_pkg::*;
(
  input  logic   i_r_type,
  input  logic   i_i_type,
  input  logic   i_load,
  input  logic   i_store,
  input  logic   i_branch,
  input  logic   i_jal,
  input  logic   i_jalr,
  output class_t o_cls
);

  // Highest-priority set flag wins so a malformed multi-hot vector still decodes deterministically
  always_comb begin
    o_cls = CLS_NONE;
    if (i_jalr)        o_cls = CLS_JALR;
    else if (i_jal)    o_cls = CLS_JAL;
    else if (i_branch) o_cls = CLS_BRANCH;
    else if (i_store)  o_cls = CLS_STORE;
    else if (i_load)   o_cls = CLS_LOAD;
    else if (i_i_type) o_cls = CLS_I;
    else if (i_r_type) o_cls = CLS_R;
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle RISC-V control FSM. Sequences each instruction
//               through FETCH, DECODE, EXEC, MEM and WB and drives the
//               register/memory/PC enables, selects and memory handshake.
//               Build option ILLEGAL_TRAP_EN: when defined, an instruction
//               with no class flag enters TRAP and raises illegal_insn until
//               reset; when undefined it retires as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       r_type,
  input  logic       i_type,
  input  logic       load,
  input  logic       store,
  input  logic       branch,
  input  logic       jal,
  input  logic       jalr,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_instr,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       alu_src_b,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       illegal_insn,
  output logic [2:0] state_o
);

  state_t     r_state;
  state_t     w_state_nxt;
  class_t     r_cls;
  class_t     w_cls_dec;

  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_mem_is_instr;
  logic       w_ir_we;
  logic       w_pc_we;
  logic [1:0] w_pc_sel;
  logic       w_alu_src_b;
  logic       w_reg_we;
  logic [1:0] w_wb_sel;

  // Class flags are only looked at through this encoder, and only in DECODE
  ctrl_class_enc u_class_enc (
    .i_r_type (r_type),
    .i_i_type (i_type),
    .i_load   (load),
    .i_store  (store),
    .i_branch (branch),
    .i_jal    (jal),
    .i_jalr   (jalr),
    .o_cls    (w_cls_dec)
  );

  // State register and class register; class is captured once per instruction in DECODE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_cls   <= CLS_NONE;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_DECODE) begin
        r_cls <= w_cls_dec;
      end
    end
  end

  // Next-state and per-state control outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_is_instr = 1'b0;
    w_ir_we        = 1'b0;
    w_pc_we        = 1'b0;
    w_pc_sel       = c_PC_SEL_PLUS4;
    w_alu_src_b    = 1'b0;
    w_reg_we       = 1'b0;
    w_wb_sel       = c_WB_SEL_ALU;

    case (r_state)
      ST_FETCH: begin
        w_mem_req      = 1'b1;
        w_mem_is_instr = 1'b1;
        if (mem_ready) begin
          w_ir_we     = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (w_cls_dec == CLS_NONE) begin
`ifdef ILLEGAL_TRAP_EN
          w_state_nxt = ST_TRAP;
`else
          // No-flag instruction skips EXEC and retires from WB as a NOP
          w_state_nxt = ST_WB;
`endif
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        w_alu_src_b = (r_cls != CLS_R) && (r_cls != CLS_BRANCH);
        case (r_cls)
          CLS_BRANCH: begin
            w_pc_we     = 1'b1;
            w_pc_sel    = branch_taken ? c_PC_SEL_TARGET : c_PC_SEL_PLUS4;
            w_state_nxt = ST_FETCH;
          end
          CLS_LOAD,
          CLS_STORE:  w_state_nxt = ST_MEM;
          default:    w_state_nxt = ST_WB;
        endcase
      end

      ST_MEM: begin
        // Request and write qualifier are held steady for the whole wait
        w_mem_req = 1'b1;
        w_mem_we  = (r_cls == CLS_STORE);
        if (mem_ready) begin
          if (r_cls == CLS_STORE) begin
            w_pc_we     = 1'b1;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_WB;
          end
        end
      end

      ST_WB: begin
        w_pc_we     = 1'b1;
        w_reg_we    = (r_cls != CLS_NONE);
        w_state_nxt = ST_FETCH;
        case (r_cls)
          CLS_LOAD: w_wb_sel = c_WB_SEL_LOAD;
          CLS_JAL: begin
            w_wb_sel = c_WB_SEL_PC4;
            w_pc_sel = c_PC_SEL_TARGET;
          end
          CLS_JALR: begin
            w_wb_sel = c_WB_SEL_PC4;
            w_pc_sel = c_PC_SEL_JALR;
          end
          default: ;
        endcase
      end

      ST_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        w_state_nxt = ST_TRAP;
`else
        w_state_nxt = ST_FETCH;
`endif
      end

      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Every output is forced low while reset is asserted, dropping any pending request
  assign mem_req      = w_mem_req & ~rst;
  assign mem_we       = w_mem_we & ~rst;
  assign mem_is_instr = w_mem_is_instr & ~rst;
  assign ir_we        = w_ir_we & ~rst;
  assign pc_we        = w_pc_we & ~rst;
  assign pc_sel       = rst ? 2'd0 : w_pc_sel;
  assign alu_src_b    = w_alu_src_b & ~rst;
  assign reg_we       = w_reg_we & ~rst;
  assign wb_sel       = rst ? 2'd0 : w_wb_sel;
  assign state_o      = rst ? 3'd0 : r_state;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_insn = (r_state == ST_TRAP) & ~rst;
`else
  assign illegal_insn = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed self-checking bench for multicycle_ctrl. Each cycle
//               the full output vector is compared to a hand-computed value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  // Flag vectors ordered {r_type, i_type, load, store, branch, jal, jalr}
  localparam logic [6:0] c_FL_NONE = 7'b0000000;
  localparam logic [6:0] c_FL_R    = 7'b1000000;
  localparam logic [6:0] c_FL_I    = 7'b0100000;
  localparam logic [6:0] c_FL_LD   = 7'b0010000;
  localparam logic [6:0] c_FL_ST   = 7'b0001000;
  localparam logic [6:0] c_FL_BR   = 7'b0000100;
  localparam logic [6:0] c_FL_JAL  = 7'b0000010;
  localparam logic [6:0] c_FL_JJR  = 7'b0000011;
  localparam logic [6:0] c_FL_BRLD = 7'b0010100;

  logic       clk = 1'b0;
  logic       rst;
  logic       r_type, i_type, load, store, branch, jal, jalr;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_is_instr, ir_we, pc_we;
  logic [1:0] pc_sel;
  logic       alu_src_b, reg_we;
  logic [1:0] wb_sel;
  logic       illegal_insn;
  logic [2:0] state_o;
  logic [14:0] obs;

  int n_chk  = 0;
  int n_pass = 0;

  multicycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .r_type       (r_type),
    .i_type       (i_type),
    .load         (load),
    .store        (store),
    .branch       (branch),
    .jal          (jal),
    .jalr         (jalr),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_is_instr (mem_is_instr),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alu_src_b    (alu_src_b),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .illegal_insn (illegal_insn),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  assign obs = {state_o, mem_req, mem_we, mem_is_instr, ir_we, pc_we,
                pc_sel, alu_src_b, reg_we, wb_sel, illegal_insn};

  // Pack an expected output vector in the same order as obs
  function automatic logic [14:0] ex(input logic [2:0] st, input logic req,
      input logic we, input logic ins, input logic ir, input logic pw,
      input logic [1:0] ps, input logic ab, input logic rw,
      input logic [1:0] ws, input logic il);
    return {st, req, we, ins, ir, pw, ps, ab, rw, ws, il};
  endfunction

  // Apply inputs for one cycle, check outputs mid-cycle, then advance
  task automatic step(input string tag, input logic rs, input logic [6:0] fl,
                      input logic rdy, input logic tk, input logic [14:0] e);
    rst = rs;
    {r_type, i_type, load, store, branch, jal, jalr} = fl;
    mem_ready    = rdy;
    branch_taken = tk;
    #1;
    n_chk++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {r_type, i_type, load, store, branch, jal, jalr} = 7'b0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    @(posedge clk);
    #1;
    // Reset: all outputs low even with mem_ready high
    step("reset",   1, c_FL_NONE, 1, 0, ex(0,0,0,0,0,0,0,0,0,0,0));

    // R-type, one fetch wait; mem_ready in DECODE/EXEC must be ignored
    step("r_f_wait",0, c_FL_NONE, 0, 0, ex(0,1,0,1,0,0,0,0,0,0,0));
    step("r_f",     0, c_FL_NONE, 1, 0, ex(0,1,0,1,1,0,0,0,0,0,0));
    step("r_d",     0, c_FL_R,    1, 0, ex(1,0,0,0,0,0,0,0,0,0,0));
    step("r_e",     0, c_FL_NONE, 1, 0, ex(2,0,0,0,0,0,0,0,0,0,0));
    step("r_wb",    0, c_FL_NONE, 0, 0, ex(4,0,0,0,0,1,0,0,1,0,0));

    // I-type: immediate operand in EXEC
    step("i_f",     0, c_FL_NONE, 1, 0, ex(0,1,0,1,1,0,0,0,0,0,0));
    step("i_d",     0, c_FL_I,    0, 0, ex(1,0,0,0,0,0,0,0,0,0,0));
    step("i_e",     0, c_FL_NONE, 0, 0, ex(2,0,0,0,0,0,0,1,0,0,0));
    step("i_wb",    0, c_FL_NONE, 0, 0, ex(4,0,0,0,0,1,0,0,1,0,0));

    // Load with two MEM wait cycles: 7-cycle instruction
    step("ld_f",    0, c_FL_NONE, 1, 0, ex(0,1,0,1,1,0,0,0,0,0,0));
    step("ld_d",    0, c_FL_LD,   0, 0, ex(1,0,0,0,0,0,0,0,0,0,0));
    step("ld_e",    0, c_FL_NONE, 0, 0, ex(2,0,0,0,0,0,0,1,0,0,0));
    step("ld_m_w1", 0, c_FL_NONE, 0, 0, ex(3,1,0,0,0,0,0,0,0,0,0));
    step("ld_m_w2", 0, c_FL_NONE, 0, 0, ex(3,1,0,0,0,0,0,0,0,0,0));
    step("ld_m",    0, c_FL_NONE, 1, 0, ex(3,1,0,0,0,0,0,0,0,0,0));
    step("ld_wb",   0, c_FL_NONE, 0, 0, ex(4,0,0,0,0,1,0,0,1,1,0));

    // Store with one MEM wait; PC advances when memory completes
    step("st_f",    0, c_FL_NONE, 1, 0, ex(0,1,0,1,1,0,0,0,0,0,0));
    step("st_d",    0, c_FL_ST,   0, 0, ex(1,0,0,0,0,0,0,0,0,0,0));
    step("st_e",    0, c_FL_NONE, 0, 0, ex(2,0,0,0,0,0,0,1,0,0,0));
    step("st_m_w",  0, c_FL_NONE, 0, 0, ex(3,1,1,0,0,0,0,0,0,0,0));
    step("st_m",    0, c_FL_NONE, 1, 0, ex(3,1,1,0,0,1,0,0,0,0,0));

    // Branch taken, then not taken, 3 cycles each
    step("bt_f",    0, c_FL_NONE, 1, 0, ex(0,1,0,1,1,0,0,0,0,0,0));
    step("bt_d",    0, c_FL_BR,   0, 0, ex(1,0,0,0,0,0,0,0,0,0,0));
    step("bt_e",    0, c_FL_NONE, 0, 1, ex(2,0,0,0,0,1,1,0,0,0,0));
    step("bn_f",    0, c_FL_NONE, 1, 1, ex(0,1,0,1,1,0,0,0,0,0,0));
    step("bn_d",    0, c_FL_BR,   0, 1, ex(1,0,0,0,0,0,0,0,0,0,0));
    step("bn_e",    0, c_FL_NONE, 0, 0, ex(2,0,0,0,0,1,0,0,0,0,0));

    // branch+load flags together decode as branch
    step("bl_f",    0, c_FL_NONE, 1, 0, ex(0,1,0,1,1,0,0,0,0,0,0));
    step("bl_d",    0, c_FL_BRLD, 0, 0, ex(1,0,0,0,0,0,0,0,0,0,0));
    step("bl_e",    0, c_FL_NONE, 0, 1, ex(2,0,0,0,0,1,1,0,0,0,0));

    // JAL
    step("jal_f",   0, c_FL_NONE, 1, 0, ex(0,1,0,1,1,0,0,0,0,0,0));
    step("jal_d",   0, c_FL_JAL,  0, 0, ex(1,0,0,0,0,0,0,0,0,0,0));
    step("jal_e",   0, c_FL_NONE, 0, 0, ex(2,0,0,0,0,0,0,1,0,0,0));
    step("jal_wb",  0, c_FL_NONE, 0, 0, ex(4,0,0,0,0,1,1,0,1,2,0));

    // jal+jalr together decode as JALR
    step("jr_f",    0, c_FL_NONE, 1, 0, ex(0,1,0,1,1,0,0,0,0,0,0));
    step("jr_d",    0, c_FL_JJR,  0, 0, ex(1,0,0,0,0,0,0,0,0,0,0));
    step("jr_e",    0, c_FL_NONE, 0, 0, ex(2,0,0,0,0,0,0,1,0,0,0));
    step("jr_wb",   0, c_FL_NONE, 0, 0, ex(4,0,0,0,0,1,2,0,1,2,0));

    // No class flag
    step("nf_f",    0, c_FL_NONE, 1, 0, ex(0,1,0,1,1,0,0,0,0,0,0));
    step("nf_d",    0, c_FL_NONE, 0, 0, ex(1,0,0,0,0,0,0,0,0,0,0));
`ifdef ILLEGAL_TRAP_EN
    step("trap_1",  0, c_FL_R,    1, 0, ex(5,0,0,0,0,0,0,0,0,0,1));
    step("trap_2",  0, c_FL_NONE, 1, 0, ex(5,0,0,0,0,0,0,0,0,0,1));
    step("trap_3",  0, c_FL_NONE, 0, 0, ex(5,0,0,0,0,0,0,0,0,0,1));
    step("trap_rst",1, c_FL_NONE, 1, 0, ex(0,0,0,0,0,0,0,0,0,0,0));
`else
    step("nop_wb",  0, c_FL_NONE, 0, 0, ex(4,0,0,0,0,1,0,0,0,0,0));
`endif

    // Reset during a MEM wait drops the request; next cycle is a fetch
    step("rl_f",    0, c_FL_NONE, 1, 0, ex(0,1,0,1,1,0,0,0,0,0,0));
    step("rl_d",    0, c_FL_LD,   0, 0, ex(1,0,0,0,0,0,0,0,0,0,0));
    step("rl_e",    0, c_FL_NONE, 0, 0, ex(2,0,0,0,0,0,0,1,0,0,0));
    step("rl_m_w",  0, c_FL_NONE, 0, 0, ex(3,1,0,0,0,0,0,0,0,0,0));
    step("rl_rst",  1, c_FL_NONE, 1, 0, ex(0,0,0,0,0,0,0,0,0,0,0));
    step("rl_f2",   0, c_FL_NONE, 0, 0, ex(0,1,0,1,0,0,0,0,0,0,0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
